// File: rtl/spi_device_if.sv
// spi_device <-> spi_flash byte bus.
// Strobes, received data and response bytes.
interface spi_device_if;
  logic [7:0] spi_rx_data;
  logic [2:0] spi_rx_bit;
  logic       spi_rx_bit_strobe;
  logic       spi_rx_strobe;
  logic       spi_rx_cmd;
  logic       spi_tx_strobe;
  logic [7:0] spi_tx_data;
  logic       spi_frame_error;

  modport slave (
    output spi_rx_data, spi_rx_bit,
    output spi_rx_bit_strobe, spi_rx_strobe,
    output spi_rx_cmd, spi_frame_error,
    input  spi_tx_strobe, spi_tx_data
  );

  modport master (
    input  spi_rx_data, spi_rx_bit,
    input  spi_rx_bit_strobe, spi_rx_strobe,
    input  spi_rx_cmd, spi_frame_error,
    output spi_tx_strobe, spi_tx_data
  );
endinterface

// File: rtl/spi_device.sv
// SPI mode-0 slave front end for spi_flash.
// Pin sync, MOSI deserializer, MISO serializer.
module spi_device #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_TX     = 8'hFF
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic spi_miso,
  spi_device_if.slave bus
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic sclk_prev_q;
  logic cs_prev_q;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;

  logic [7:0] rx_data_q;
  logic [2:0] rx_bit_q;
  logic       bit_stb_q;
  logic       rx_stb_q;
  logic       rx_cmd_q;
  logic       ferr_q;
  logic [2:0] cnt_q;
  logic       first_q;
  logic       armed_q;
  logic [7:0] hold_q;
  logic [7:0] tx_sh_q;
  logic       late_q;

  // Pin synchronizers plus previous-level flops for edge detect.
  // /CS chain resets low so a mid-frame reset stays disarmed
  // until /CS is genuinely seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  // Frame state: rx shift, bit counter, strobes, tx path.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_q <= 8'h00;
      rx_bit_q  <= 3'd0;
      bit_stb_q <= 1'b0;
      rx_stb_q  <= 1'b0;
      rx_cmd_q  <= 1'b0;
      ferr_q    <= 1'b0;
      cnt_q     <= 3'd0;
      first_q   <= 1'b1;
      armed_q   <= 1'b0;
      hold_q    <= IDLE_TX;
      tx_sh_q   <= 8'hFF;
      late_q    <= 1'b0;
    end else begin
      bit_stb_q <= 1'b0;
      rx_stb_q  <= 1'b0;
      rx_cmd_q  <= 1'b0;
      ferr_q    <= 1'b0;
      if (cs_s) begin
        armed_q <= 1'b1;
        cnt_q   <= 3'd0;
        first_q <= 1'b1;
        hold_q  <= IDLE_TX;
        late_q  <= 1'b0;
        if (cs_rise && cnt_q != 3'd0)
          ferr_q <= 1'b1;
      end else if (armed_q) begin
        if (sclk_rise) begin
          rx_data_q <= {rx_data_q[6:0], mosi_s};
          rx_bit_q  <= cnt_q;
          bit_stb_q <= 1'b1;
          cnt_q     <= cnt_q + 3'd1;
          late_q    <= 1'b0;
          if (cnt_q == 3'd7) begin
            rx_stb_q <= 1'b1;
            rx_cmd_q <= first_q;
            first_q  <= 1'b0;
          end
        end
        if (sclk_fall && cnt_q == 3'd0) begin
          tx_sh_q <= bus.spi_tx_strobe ? bus.spi_tx_data : hold_q;
          hold_q  <= IDLE_TX;
          late_q  <= 1'b1;
        end else begin
          if (sclk_fall)
            tx_sh_q <= {tx_sh_q[6:0], 1'b1};
          if (bus.spi_tx_strobe) begin
            if (late_q) begin
              tx_sh_q <= bus.spi_tx_data;
              hold_q  <= IDLE_TX;
            end else begin
              hold_q  <= bus.spi_tx_data;
            end
          end
        end
      end
    end
  end

  assign spi_miso              = tx_sh_q[7];
  assign bus.spi_rx_data       = rx_data_q;
  assign bus.spi_rx_bit        = rx_bit_q;
  assign bus.spi_rx_bit_strobe = bit_stb_q;
  assign bus.spi_rx_strobe     = rx_stb_q;
  assign bus.spi_rx_cmd        = rx_cmd_q;
  assign bus.spi_frame_error   = ferr_q;

endmodule

// File: tb/tb_spi_device.sv
// Directed bench for spi_device.
// Mode-0 master model, strobe monitor.
module tb_spi_device;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic reset;
  logic spi_clk;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;

  spi_device_if bus ();

  spi_device dut (
    .clk      (clk),
    .reset    (reset),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] bit_q[$];
  logic [7:0] bdat_q[$];
  logic [7:0] byte_q[$];
  logic       cmd_q[$];
  int         ferr_n = 0;
  int         rstb_n = 0;

  always @(negedge clk) begin
    if (bus.spi_rx_bit_strobe) begin
      bit_q.push_back(bus.spi_rx_bit);
      bdat_q.push_back(bus.spi_rx_data);
    end
    if (bus.spi_rx_strobe) begin
      byte_q.push_back(bus.spi_rx_data);
      cmd_q.push_back(bus.spi_rx_cmd);
      rstb_n++;
    end
    if (bus.spi_frame_error)
      ferr_n++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    bit_q.delete();
    bdat_q.delete();
    byte_q.delete();
    cmd_q.delete();
    ferr_n = 0;
    rstb_n = 0;
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_cs = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic xfer(input logic [7:0] d, input int nbits,
                      output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = d[i];
      wait_clk(HALF);
      rd = {rd[6:0], spi_miso};
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
  endtask

  function automatic logic [31:0] byte_at(input int i);
    return (i < byte_q.size()) ? {24'h0, byte_q[i]} : 32'hDEAD;
  endfunction

  function automatic logic [31:0] cmd_at(input int i);
    return (i < cmd_q.size()) ? {31'h0, cmd_q[i]} : 32'hDEAD;
  endfunction

  logic [7:0] rd;
  int         n;
  logic [7:0] seq [4];

  initial begin
    reset    = 1'b1;
    spi_clk  = 1'b0;
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    bus.spi_tx_strobe = 1'b0;
    bus.spi_tx_data   = 8'h00;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);

    check("rst_miso", spi_miso, 1);
    check("rst_rx_data", bus.spi_rx_data, 8'h00);
    check("rst_rx_bit", bus.spi_rx_bit, 0);
    check("rst_strobes",
          {bus.spi_rx_bit_strobe, bus.spi_rx_strobe,
           bus.spi_rx_cmd, bus.spi_frame_error}, 0);

    clear_logs();
    cs_low();
    xfer(8'h9F, 8, rd);
    cs_high();
    check("9f_nbits", bit_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check("9f_bitidx",
            (i < bit_q.size()) ? {29'h0, bit_q[i]} : 32'hDEAD, i);
    check("9f_nbytes", byte_q.size(), 1);
    check("9f_data", byte_at(0), 8'h9F);
    check("9f_cmd", cmd_at(0), 1);
    check("9f_ferr", ferr_n, 0);

    clear_logs();
    seq[0] = 8'h03; seq[1] = 8'h12;
    seq[2] = 8'h34; seq[3] = 8'h56;
    cs_low();
    for (int b = 0; b < 4; b++)
      xfer(seq[b], 8, rd);
    cs_high();
    check("seq_nbytes", byte_q.size(), 4);
    for (int b = 0; b < 4; b++) begin
      check("seq_data", byte_at(b), seq[b]);
      check("seq_cmd", cmd_at(b), (b == 0) ? 1 : 0);
    end
    check("seq_bit30",
          (bit_q.size() > 30) ? {29'h0, bit_q[30]} : 32'hDEAD, 6);
    check("seq_dat30",
          (bdat_q.size() > 30) ? {25'h0, bdat_q[30][6:0]} : 32'hDEAD,
          7'h2B);

    clear_logs();
    cs_low();
    fork
      xfer(8'h05, 8, rd);
      begin
        n = 0;
        while (!bus.spi_rx_cmd && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("tx_cmd_seen", (n < 400) ? 1 : 0, 1);
        bus.spi_tx_data   = 8'hA5;
        bus.spi_tx_strobe = 1'b1;
        @(negedge clk);
        bus.spi_tx_strobe = 1'b0;
      end
    join
    xfer(8'h00, 8, rd);
    check("tx_miso_a5", rd, 8'hA5);
    xfer(8'h00, 8, rd);
    check("tx_miso_idle", rd, 8'hFF);
    cs_high();

    clear_logs();
    cs_low();
    xfer(8'h0B, 8, rd);
    wait_clk(4);
    bus.spi_tx_data   = 8'h3C;
    bus.spi_tx_strobe = 1'b1;
    @(negedge clk);
    bus.spi_tx_strobe = 1'b0;
    xfer(8'h00, 8, rd);
    check("late_miso_3c", rd, 8'h3C);
    cs_high();

    clear_logs();
    cs_low();
    xfer(8'hB7, 5, rd);
    cs_high();
    check("fe_count", ferr_n, 1);
    check("fe_no_rxstb", rstb_n, 0);
    clear_logs();
    cs_low();
    xfer(8'h9F, 8, rd);
    cs_high();
    check("fe_next_data", byte_at(0), 8'h9F);
    check("fe_next_cmd", cmd_at(0), 1);

    clear_logs();
    cs_low();
    xfer(8'hAA, 4, rd);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mr_miso", spi_miso, 1);
    check("mr_rx_data", bus.spi_rx_data, 8'h00);
    check("mr_rx_bit", bus.spi_rx_bit, 0);
    clear_logs();
    xfer(8'hF0, 4, rd);
    check("mr_ignored", bit_q.size(), 0);
    cs_high();
    check("mr_ferr", ferr_n, 0);
    clear_logs();
    cs_low();
    xfer(8'h9F, 8, rd);
    cs_high();
    check("mr_next_data", byte_at(0), 8'h9F);
    check("mr_next_cmd", cmd_at(0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_device.md
# spi_device

Bus-side SPI slave front end feeding `spi_flash`. It synchronizes the raw flash-socket pins (SCLK, /CS, MOSI) into the system clock domain and deserializes MOSI into bytes. It produces the per-bit and per-byte strobes `spi_flash` consumes, and serializes the response bytes `spi_flash` hands back onto MISO. The block supports SPI mode 0 only (CPOL=0, CPHA=0), MSB first.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in each pin synchronizer (≥2).
- `IDLE_TX`, default 8'hFF: byte shifted out when no response is pending.

Ports:
- `clk`  in  1  system clock. All logic runs on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `spi_clk`  in  1  raw SCLK pin, asynchronous.
- `spi_cs`  in  1  raw /CS pin, active low, asynchronous.
- `spi_mosi`  in  1  raw MOSI pin, asynchronous.
- `spi_miso`  out  1  serial data out. Tri-stating is done at top level using `spi_flash.spi_output_enable`.
- `spi_rx_data`  out  8  live receive shift register. Newest bit is in [0].
- `spi_rx_bit`  out  3  index (0..7) of the bit most recently received in the current byte.
- `spi_rx_bit_strobe`  out  1  one-cycle pulse per sampled bit.
- `spi_rx_strobe`  out  1  one-cycle pulse when the 8th bit of a byte is sampled.
- `spi_rx_cmd`  out  1  one-cycle pulse, coincident with `spi_rx_strobe`, for the first byte after /CS falls.
- `spi_tx_strobe`  in  1  pulse: `spi_tx_data` is the next byte to send.
- `spi_tx_data`  in  8  response byte.
- `spi_frame_error`  out  1  one-cycle pulse when /CS rises with a partial byte received.

## Operation
- Synchronizers: each pin passes through `SYNC_STAGES` flops. One more flop holds the previous synchronized SCLK, which gives `sclk_rise` and `sclk_fall`. Edge logic acts only while the synchronized /CS is low.
- Idle, /CS high:
  - bit counter cleared to 0; `first_byte` set to 1.
  - tx holding register set to `IDLE_TX`; `tx_late` cleared.
  - all strobes 0.
  - `spi_rx_data` retains its last value.
- `sclk_rise`, /CS low:
  - `spi_rx_data <= {spi_rx_data[6:0], mosi_sync}`.
  - `spi_rx_bit <=` bit counter; `spi_rx_bit_strobe` = 1.
  - bit counter increments, wrapping 7→0.
  - When the counter was 7: `spi_rx_strobe` = 1, and `spi_rx_cmd` = `first_byte`. Then `first_byte` clears.
  - Clears `tx_late`.
- `sclk_fall`, /CS low:
  - Bit counter == 0 (byte boundary): tx shift register is loaded from the holding register, the holding register is set to `IDLE_TX`, and `tx_late` is set.
  - Otherwise: the tx shift register shifts left, filling with 1.
  - `spi_miso` = tx shift register [7] at all times.
- `spi_tx_strobe`:
  - Writes `spi_tx_data` into the holding register.
  - If `tx_late` = 1 (the load edge already passed, no rising edge yet), the byte also goes directly into the tx shift register and the holding register becomes `IDLE_TX`. This rescues a response that arrives after the falling edge.
- /CS rising (synchronized) with bit counter ≠ 0: `spi_frame_error` pulses and the partial byte is discarded, with no `spi_rx_strobe`.
- /CS falling: no strobe. The first `sclk_rise` after it is bit 0 of the command byte.

## Timing
- Reset values: `spi_miso`=1, `spi_rx_data`=0, `spi_rx_bit`=0, all strobes=0, holding register=`IDLE_TX`, tx shift register=8'hFF, `first_byte`=1.
- Pin edge → strobe latency: `SYNC_STAGES`+1 clk cycles. Strobes are exactly one cycle wide.
- `spi_rx_data` is valid in the same cycle as its strobe and holds until the next `sclk_rise`.
- Response deadline: `spi_tx_strobe` must occur before the falling SCLK that follows the byte's 8th rising edge; the late-load path extends this to the next rising edge.
- `clk` must be ≥ 8× SCLK so each half-period spans at least `SYNC_STAGES`+2 cycles.
- If `spi_tx_strobe` and a load `sclk_fall` occur in the same cycle, the new byte is loaded into the shift register and the holding register becomes `IDLE_TX`.
- Reset asserted mid-byte clears state the next cycle. Subsequent bits of that transaction are treated as bits of a new first byte only after /CS has been seen high.

## Test plan
- Send 0x9F with /CS low, then /CS high → 8 bit strobes with `spi_rx_bit` 0..7. On the last, `spi_rx_strobe` = `spi_rx_cmd` = 1 with `spi_rx_data`=0x9F. No `spi_frame_error`.
- Send 0x03,0x12,0x34,0x56 → `spi_rx_cmd` only on 0x03. At the 7th bit of byte 4, `spi_rx_bit`=6 and `spi_rx_data[6:0]`=0x56>>1=0x2B.
- Send 0x05; strobe `spi_tx_data`=0xA5 with `spi_rx_cmd`; clock 8 more bits → MISO reads 0xA5 MSB first. A following byte with no strobe reads 0xFF.
- Late response: strobe 0x3C two clk cycles after the boundary `sclk_fall` → MISO still reads 0x3C.
- Raise /CS after 5 bits → one `spi_frame_error` pulse, no `spi_rx_strobe`. The next transaction's first byte asserts `spi_rx_cmd`.
- Assert `reset` mid-byte → outputs return to reset values. The next full transaction decodes correctly.
